// File: rtl/count_event_logger_pkg.sv
// Shared constants for count_event_logger: event type codes and record layout.
// Record = {type, count, timestamp}, always RECORD_W bits wide.
package count_event_logger_pkg;

  localparam int RECORD_W     = 32;
  localparam int TYPE_W       = 2;
  localparam int TYPE_LSB     = RECORD_W - TYPE_W;
  localparam int CW_DEFAULT   = 8;
  localparam int TS_W_DEFAULT = RECORD_W - TYPE_W - CW_DEFAULT;
  localparam int COUNT_LSB    = TS_W_DEFAULT;

  typedef enum logic [TYPE_W-1:0] {
    EV_NONE   = 2'b00,
    EV_CHANGE = 2'b01,
    EV_MATCH  = 2'b10,
    EV_WRAP   = 2'b11
  } ev_type_e;

  // Highest-priority active event wins; EV_NONE means no record this cycle.
  function automatic ev_type_e ev_select(input logic wrap, input logic match,
                                         input logic change);
    if (wrap)        return EV_WRAP;
    else if (match)  return EV_MATCH;
    else if (change) return EV_CHANGE;
    else             return EV_NONE;
  endfunction

endpackage

// File: rtl/count_event_logger_fifo.sv
// event_fifo: synchronous first-word-fall-through FIFO with async reset.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module event_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  input  logic                     clear,
  output logic [W-1:0]             dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          wr_ok;
  logic          rd_ok;

  assign empty = (level == '0);
  assign full  = (level == LW'(DEPTH));
  assign wr_ok = push && (!full || pop);
  assign rd_ok = pop && !empty;
  assign dout  = empty ? '0 : mem[rd_ptr];

  // NOTE: storage has no reset; empty masks dout, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (wr_ok && !clear)
      mem[wr_ptr] <= din;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_ok, rd_ok})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/count_event_logger.sv
// count_event_logger: detects change/match/wrap on a counter, timestamps and queues records.
// Optional: define COUNT_EVENT_LOGGER_MATCH_EN to build the match comparator.
module count_event_logger
  import count_event_logger_pkg::*;
#(
  parameter int CW    = CW_DEFAULT,
  parameter int TSW   = RECORD_W - TYPE_W - CW,
  parameter int DEPTH = 16
) (
  input  logic                     sys_clk,
  input  logic                     reset,
  input  logic [CW-1:0]            count,
  input  logic                     en_change,
  input  logic [CW-1:0]            match_val,
  input  logic                     rd_pop,
  input  logic                     clear,
  output logic [RECORD_W-1:0]      dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
);

  logic [TSW-1:0]      ts;
  logic [CW-1:0]       count_q;
  logic                armed;
  logic                is_wrap;
  logic                is_match;
  logic                is_change;
  ev_type_e            ev_type;
  logic                ev_valid;
  logic [RECORD_W-1:0] record;

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      ts      <= '0;
      count_q <= '0;
      armed   <= 1'b0;
    end else begin
      ts      <= ts + TSW'(1);
      count_q <= count;
      armed   <= 1'b1;
    end
  end

  assign is_wrap   = (count_q == '1) && (count == '0);
  assign is_change = en_change && (count != count_q);

`ifdef COUNT_EVENT_LOGGER_MATCH_EN
  assign is_match  = (count == match_val) && (count_q != match_val);
`else
  logic unused_match_val;
  assign unused_match_val = ^match_val;
  assign is_match  = 1'b0;
`endif

  // The first sample after reset only primes count_q, so armed gates every event.
  assign ev_type  = ev_select(is_wrap, is_match, is_change);
  assign ev_valid = armed && (ev_type != EV_NONE);
  assign record   = {ev_type, count, ts};

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset)
      overflow <= 1'b0;
    else if (clear)
      overflow <= 1'b0;
    else if (ev_valid && full && !rd_pop)
      overflow <= 1'b1;
  end

  event_fifo #(
    .W     (RECORD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (sys_clk),
    .reset (reset),
    .push  (ev_valid),
    .din   (record),
    .pop   (rd_pop),
    .clear (clear),
    .dout  (dout),
    .empty (empty),
    .full  (full),
    .level (level)
  );

endmodule

// File: doc/count_event_logger.md
# count_event_logger

Downstream consumer of a free-running 8-bit counter value in the sys_clk domain (e.g. count1/count2 from the counters block). It detects change, match and wrap events on the count, stamps each with a free-running cycle timestamp, and buffers one 32-bit record per event in a small FIFO. The host drains the FIFO through a wire-out (head record plus status) and a trigger-in (pop/clear).

## Interface
Parameters:
- CW, 8: counter width; record = {type[1:0], count[CW-1:0], ts[TSW-1:0]}
- TSW, 32-2-CW (22): timestamp width; derived, not overridden
- DEPTH, 16: FIFO entries; power of two, >= 2

Ports:
- sys_clk  in  1  sole clock
- reset  in  1  asynchronous, active-high
- count  in  CW  observed counter value, sys_clk domain
- en_change  in  1  enable change events
- match_val  in  CW  match compare value
- rd_pop  in  1  one-cycle pulse; pops head record
- clear  in  1  one-cycle pulse; flushes FIFO and overflow
- dout  out  32  head record, first-word-fall-through; 0 when empty
- empty  out  1  FIFO empty
- full  out  1  FIFO holds DEPTH records
- level  out  $clog2(DEPTH)+1  records held
- overflow  out  1  sticky; a record was dropped

## Operation
- Reset values: dout=0, empty=1, full=0, level=0, overflow=0; timestamp=0, count_q=0, armed=0.
- The timestamp increments every cycle and wraps modulo 2^TSW.
- count_q registers count every cycle. armed sets on the first edge after reset. All events are suppressed while armed=0.
- Event conditions, evaluated combinationally in cycle k with armed=1:
  - wrap: count_q = all-ones and count = 0
  - match: count = match_val and count_q != match_val
  - change: en_change=1 and count != count_q
- At most one record per cycle. The type is the highest-priority active event: wrap=2'b11 > match=2'b10 > change=2'b01. Type 2'b00 never occurs in a stored record.
- Record fields: type, count (new value), and the timestamp of cycle k.
- Push while not full, or while full with rd_pop in the same cycle: record stored.
- Push while full with no pop: record dropped, overflow set.
- rd_pop while empty: ignored, no flag.
- Push and pop in the same cycle: level unchanged.
- clear has priority over everything in its cycle:
  - level→0, overflow→0; read/write pointers reset.
  - Any same-cycle event is discarded and is not counted as overflow.
  - The timestamp is not cleared.

## Timing
- Event in cycle k: written at edge k+1. If the FIFO was empty, empty drops and dout shows the record after edge k+1 (latency 1).
- rd_pop in cycle k: dout shows the next record (or 0, empty=1) after edge k+1.
- full, level and overflow are registered and update at the same edge as the push/pop that changes them.
- Reset asserted mid-operation clears all state asynchronously. After release, the first count sample only primes count_q.

## Configuration
- COUNT_EVENT_LOGGER_MATCH_EN defined: the match comparator is present and events behave as above.
- Undefined: no comparator is built and match_val is ignored. Type 2'b10 is never produced. A value that would have matched yields a change record if en_change=1.

## Structure
- Package count_event_logger_pkg holds:
  - event type constants EV_CHANGE, EV_MATCH, EV_WRAP
  - record field offsets/widths (TYPE_LSB=30, COUNT_LSB=TSW)
  - RECORD_W=32
- One sub-module, event_fifo: synchronous FWFT FIFO with async reset. It has push, pop, clear, dout, empty, full and level. It is parameterised by width and depth.
- The top level holds the detector, timestamp counter and overflow flag.

## Test plan
- Reset, then count steps 0→1 with en_change=1: one record with type 01, count 01, ts equal to that cycle's stamp. dout is valid one cycle later, level=1.
- count 8'hFF→8'h00 with match_val=0, MATCH_EN defined: a single record with type 11 (wrap beats match). Undefined: also type 11, no extra record.
- match_val=8'h80, en_change=0, count ramps 7E→7F→80→81: exactly one record, type 10, count 80. Without MATCH_EN: no record.
- 17 change events with no pops, DEPTH=16: full=1, level=16, overflow=1. Then 16 pops return the first 16 records in order, followed by empty=1 and dout=0.
- With full=1, an event and rd_pop in the same cycle: level stays 16 and overflow stays 0.
- clear coincident with an event: level=0, overflow=0, no record stored. Reset asserted mid-burst: all outputs return to reset values, and the first count after release produces no event.
